// File: rtl/vga_sync_gen.sv
// VGA raster timing generator, 800x600@60Hz at a 40 MHz pixel clock by default.
// A free-running horizontal/vertical counter pair is decoded into regions.
// Stage 1 registers the pixel request, the pixel coordinates and the raw syncs.
// Stage 2 registers the blanked RGB from upstream together with the syncs and DE,
// so everything at the pins lines up two clocks after the count.
module vga_sync_gen #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 40,
  parameter int   H_SYNC   = 128,
  parameter int   H_BP     = 88,
  parameter int   V_ACTIVE = 600,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 4,
  parameter int   V_BP     = 23,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   RGB_W    = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  output logic [10:0]      pixel_x,
  output logic [9:0]       pixel_y,
  output logic             pixel_req,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             line_start,
  output logic             frame_start,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_de,
  output logic [RGB_W-1:0] vga_rgb
);

  localparam logic [10:0] H_FP_START   = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_BP_START   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST       = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_FP_START   = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  V_LAST       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic        h_last, v_last;
  logic        h_act, v_act, in_active;
  logic        h_sync, v_sync;
  logic        hs1, vs1;

  // Region decode; >= on the terminal compare keeps the counters bounded.
  assign h_last    = (hcnt >= H_LAST);
  assign v_last    = (vcnt >= V_LAST);
  assign h_act     = (hcnt < H_FP_START);
  assign v_act     = (vcnt < V_FP_START);
  assign in_active = h_act & v_act;
  assign h_sync    = (hcnt >= H_SYNC_START) && (hcnt < H_BP_START);
  assign v_sync    = (vcnt >= V_SYNC_START) && (vcnt < V_BP_START);

  // Raster counters: hcnt wraps every line, vcnt advances on the hcnt wrap.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= v_last ? '0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 11'd1;
    end
  end

  // Stage 1: pixel request to upstream, frame/line markers and raw syncs.
  // vs1 follows vcnt only, so vsync switches at hcnt=0, independent of hsync.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pixel_req   <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hs1         <= ~HS_POL;
      vs1         <= ~VS_POL;
    end else begin
      pixel_req   <= in_active;
      pixel_x     <= in_active ? hcnt : '0;
      pixel_y     <= in_active ? vcnt : '0;
      line_start  <= (hcnt == 11'd0) && v_act;
      frame_start <= (hcnt == 11'd0) && (vcnt == 10'd0);
      hs1         <= h_sync ? HS_POL : ~HS_POL;
      vs1         <= v_sync ? VS_POL : ~VS_POL;
    end
  end

  // Stage 2: capture upstream pixel while stage 1 is valid, delay syncs/DE to match.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      vga_rgb <= '0;
      vga_hs  <= ~HS_POL;
      vga_vs  <= ~VS_POL;
      vga_de  <= 1'b0;
    end else begin
      vga_rgb <= pixel_req ? rgb_in : '0;
      vga_hs  <= hs1;
      vga_vs  <= vs1;
      vga_de  <= pixel_req;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. Two instances share the clock: "b" uses the full
// 800x600 timing, "s" keeps the full vertical timing but a 16-clock line so
// whole frames, the frame wrap and a line-300 reset fit in a short run.
module tb_vga_sync_gen;

  typedef struct {
    int          k;      // rising edges since reset release
    bit          sel;    // 0 = big instance, 1 = short-line instance
    logic        fs, ls, req;
    logic [10:0] px;
    logic [9:0]  py;
    logic        hs, vs, de;
    logic [15:0] rgb;
  } vec_t;

  localparam int NV = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_s = 1'b1;
  logic ff_mode = 1'b0;

  logic [10:0] px_b, px_s;
  logic [9:0]  py_b, py_s;
  logic        req_b, req_s, ls_b, ls_s, fs_b, fs_s;
  logic        hs_b, hs_s, vs_b, vs_s, de_b, de_s;
  logic [15:0] rgbi_b, rgbi_s, rgbo_b, rgbo_s;

  int cyc_b = 0, cyc_s = 0;
  int nvec = 0, nerr = 0;
  int phase = 0;
  vec_t tv[NV];

  // monitor records
  int first_de = -1, hs_r1 = -1, hs_r2 = -1, hs_w = -1, de0 = 0, de1 = 0;
  int vs_r1 = -1, vs_r2 = -1, vs_w = -1, fs1 = -1, fs2 = -1, fs_cnt = 0, ls_cnt = 0;
  logic hs_prev = 1'b0, vs_prev = 1'b0;

  always #5 clk = ~clk;

  assign rgbi_b = ff_mode ? 16'hFFFF : {px_b[4:0], py_b[5:0], px_b[4:0]};
  assign rgbi_s = {px_s[4:0], py_s[5:0], px_s[4:0]};

  vga_sync_gen dut_b (
    .clk_in(clk), .rst(rst), .pixel_x(px_b), .pixel_y(py_b), .pixel_req(req_b),
    .rgb_in(rgbi_b), .line_start(ls_b), .frame_start(fs_b), .vga_hs(hs_b),
    .vga_vs(vs_b), .vga_de(de_b), .vga_rgb(rgbo_b)
  );

  vga_sync_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3)) dut_s (
    .clk_in(clk), .rst(rst_s), .pixel_x(px_s), .pixel_y(py_s), .pixel_req(req_s),
    .rgb_in(rgbi_s), .line_start(ls_s), .frame_start(fs_s), .vga_hs(hs_s),
    .vga_vs(vs_s), .vga_de(de_s), .vga_rgb(rgbo_s)
  );

  always @(posedge clk or posedge rst) if (rst) cyc_b <= 0; else cyc_b <= cyc_b + 1;
  always @(posedge clk or posedge rst_s) if (rst_s) cyc_s <= 0; else cyc_s <= cyc_s + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic vec_t mkv(int k, int sel, int fs, int ls, int req, int px, int py,
                               int hs, int vs, int de, logic [15:0] rgb);
    vec_t v;
    v.k = k; v.sel = (sel != 0);
    v.fs = (fs != 0); v.ls = (ls != 0); v.req = (req != 0);
    v.px = 11'(px); v.py = 10'(py);
    v.hs = (hs != 0); v.vs = (vs != 0); v.de = (de != 0);
    v.rgb = rgb;
    return v;
  endfunction

  function automatic logic [63:0] pack(logic fs, logic ls, logic req, logic [10:0] px,
                                       logic [9:0] py, logic hs, logic vs, logic de,
                                       logic [15:0] rgb);
    return {21'b0, fs, ls, req, px, py, hs, vs, de, rgb};
  endfunction

  // Expected {de, rgb} at the pins for raster count n (pins lag the count by 2 clks).
  function automatic logic [16:0] model(int n, int ht, int ha, bit ff);
    int h, v;
    logic [31:0] hv, vv;
    h = n % ht;
    v = (n / ht) % 628;
    hv = h;
    vv = v;
    if (h < ha && v < 600) return {1'b1, ff ? 16'hFFFF : {hv[4:0], vv[5:0], hv[4:0]}};
    return 17'd0;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s (cyc_b=%0d cyc_s=%0d): got %0h, expected %0h", name, cyc_b, cyc_s, act, exp);
    end
  endtask

  task automatic tick();
    logic [16:0] m;
    @(negedge clk);
    if (phase == 1) begin
      if (cyc_b >= 2 && cyc_b < 2 + 3*1056) begin
        m = model(cyc_b - 2, 1056, 800, 1'b0);
        chk("pix_b", 64'({de_b, rgbo_b}), 64'(m));
      end
      if (de_b && first_de < 0) first_de = cyc_b;
      if (de_b && cyc_b >= 2 && cyc_b < 1058) de0++;
      if (de_b && cyc_b >= 1058 && cyc_b < 2114) de1++;
      if (hs_b && !hs_prev) begin
        if (hs_r1 < 0) hs_r1 = cyc_b; else if (hs_r2 < 0) hs_r2 = cyc_b;
      end
      if (!hs_b && hs_prev && hs_w < 0) hs_w = cyc_b - hs_r1;
      hs_prev = hs_b;

      if (cyc_s >= 2 && cyc_s < 2 + 10048) begin
        m = model(cyc_s - 2, 16, 8, 1'b0);
        chk("pix_s", 64'({de_s, rgbo_s}), 64'(m));
      end
      if (fs_s) begin
        fs_cnt++;
        if (fs1 < 0) fs1 = cyc_s; else if (fs2 < 0) fs2 = cyc_s;
      end
      if (ls_s && cyc_s <= 10048) ls_cnt++;
      if (vs_s && !vs_prev) begin
        if (vs_r1 < 0) vs_r1 = cyc_s; else if (vs_r2 < 0) vs_r2 = cyc_s;
      end
      if (!vs_s && vs_prev && vs_w < 0) vs_w = cyc_s - vs_r1;
      vs_prev = vs_s;
    end
  endtask

  task automatic run_table(bit only, bit sel, int kmax);
    for (int i = 0; i < NV; i++) begin
      if (tv[i].k > kmax) break;
      if (!only || tv[i].sel == sel) begin
        while ((tv[i].sel ? cyc_s : cyc_b) < tv[i].k) tick();
        if (tv[i].sel)
          chk($sformatf("vec%0d_s", i),
              pack(fs_s, ls_s, req_s, px_s, py_s, hs_s, vs_s, de_s, rgbo_s),
              pack(tv[i].fs, tv[i].ls, tv[i].req, tv[i].px, tv[i].py, tv[i].hs, tv[i].vs, tv[i].de, tv[i].rgb));
        else
          chk($sformatf("vec%0d_b", i),
              pack(fs_b, ls_b, req_b, px_b, py_b, hs_b, vs_b, de_b, rgbo_b),
              pack(tv[i].fs, tv[i].ls, tv[i].req, tv[i].px, tv[i].py, tv[i].hs, tv[i].vs, tv[i].de, tv[i].rgb));
      end
    end
  endtask

  initial begin
    //            k      sel fs ls rq px   py  hs vs de rgb
    tv[0]  = mkv(1,     0, 1, 1, 1, 0,   0,   0, 0, 0, 16'h0000);
    tv[1]  = mkv(1,     1, 1, 1, 1, 0,   0,   0, 0, 0, 16'h0000);
    tv[2]  = mkv(2,     0, 0, 0, 1, 1,   0,   0, 0, 1, 16'h0000);
    tv[3]  = mkv(3,     0, 0, 0, 1, 2,   0,   0, 0, 1, 16'h0801);
    tv[4]  = mkv(9,     1, 0, 0, 0, 0,   0,   0, 0, 1, 16'h3807);
    tv[5]  = mkv(12,    1, 0, 0, 0, 0,   0,   1, 0, 0, 16'h0000);
    tv[6]  = mkv(801,   0, 0, 0, 0, 0,   0,   0, 0, 1, 16'hF81F);
    tv[7]  = mkv(802,   0, 0, 0, 0, 0,   0,   0, 0, 0, 16'h0000);
    tv[8]  = mkv(841,   0, 0, 0, 0, 0,   0,   0, 0, 0, 16'h0000);
    tv[9]  = mkv(842,   0, 0, 0, 0, 0,   0,   1, 0, 0, 16'h0000);
    tv[10] = mkv(969,   0, 0, 0, 0, 0,   0,   1, 0, 0, 16'h0000);
    tv[11] = mkv(970,   0, 0, 0, 0, 0,   0,   0, 0, 0, 16'h0000);
    tv[12] = mkv(1057,  0, 0, 1, 1, 0,   1,   0, 0, 0, 16'h0000);
    tv[13] = mkv(1058,  0, 0, 0, 1, 1,   1,   0, 0, 1, 16'h0020);
    tv[14] = mkv(2159,  0, 0, 0, 1, 46,  2,   0, 0, 1, 16'h684D);
    tv[15] = mkv(9592,  1, 0, 0, 1, 7,   599, 0, 0, 1, 16'h32E6);
    tv[16] = mkv(9593,  1, 0, 0, 0, 0,   0,   0, 0, 1, 16'h3AE7);
    tv[17] = mkv(9617,  1, 0, 0, 0, 0,   0,   0, 0, 0, 16'h0000);
    tv[18] = mkv(9618,  1, 0, 0, 0, 0,   0,   0, 1, 0, 16'h0000);
    tv[19] = mkv(9681,  1, 0, 0, 0, 0,   0,   0, 1, 0, 16'h0000);
    tv[20] = mkv(9682,  1, 0, 0, 0, 0,   0,   0, 0, 0, 16'h0000);
    tv[21] = mkv(10048, 1, 0, 0, 0, 0,   0,   0, 0, 0, 16'h0000);
    tv[22] = mkv(10049, 1, 1, 1, 1, 0,   0,   0, 0, 0, 16'h0000);
    tv[23] = mkv(10050, 1, 0, 0, 1, 1,   0,   0, 0, 1, 16'h0000);

    // reset held
    repeat (4) tick();
    chk("rst_b", pack(fs_b, ls_b, req_b, px_b, py_b, hs_b, vs_b, de_b, rgbo_b), 64'd0);
    chk("rst_s", pack(fs_s, ls_s, req_s, px_s, py_s, hs_s, vs_s, de_s, rgbo_s), 64'd0);
    rst = 1'b0;
    rst_s = 1'b0;
    phase = 1;

    run_table(1'b0, 1'b0, 32'h7fffffff);
    while (cyc_s < 19700) tick();
    phase = 0;

    chk("first_de", 64'(first_de), 64'd2);
    chk("hs_rise_after_de", 64'(hs_r1 - first_de), 64'd840);
    chk("hs_period", 64'(hs_r2 - hs_r1), 64'd1056);
    chk("hs_width", 64'(hs_w), 64'd128);
    chk("de_line0", 64'(de0), 64'd800);
    chk("de_line1", 64'(de1), 64'd800);
    chk("fs_first", 64'(fs1), 64'd1);
    chk("fs_second", 64'(fs2), 64'd10049);
    chk("fs_count", 64'(fs_cnt), 64'd2);
    chk("ls_per_frame", 64'(ls_cnt), 64'd600);
    // vs_r1 is a pin edge, frame_start a stage-1 flag: 601 lines plus one clock
    chk("vs_rise_after_fs", 64'(vs_r1 - fs1), 64'd9617);
    chk("vs_period", 64'(vs_r2 - vs_r1), 64'd10048);
    chk("vs_width", 64'(vs_w), 64'd64);

    // rgb_in forced high: pins must still blank outside active video
    ff_mode = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      logic [16:0] m;
      tick();
      m = model(cyc_b - 2, 1056, 800, 1'b1);
      chk("blank_ff", 64'({de_b, rgbo_b}), 64'(m));
    end
    ff_mode = 1'b0;

    // big instance: reset at line 20, x=400
    while (cyc_b < 21520) tick();
    chk("pre_rst_de_b", 64'(de_b), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_b", pack(fs_b, ls_b, req_b, px_b, py_b, hs_b, vs_b, de_b, rgbo_b), 64'd0);
    repeat (3) tick();
    chk("hold_rst_b", pack(fs_b, ls_b, req_b, px_b, py_b, hs_b, vs_b, de_b, rgbo_b), 64'd0);
    rst = 1'b0;
    run_table(1'b1, 1'b0, 1058);

    // short-line instance: reset at line 300, x=4 of the third frame
    while (cyc_s < 24900) tick();
    chk("pre_rst_de_s", 64'(de_s), 64'd1);
    rst_s = 1'b1;
    #1;
    chk("async_rst_s", pack(fs_s, ls_s, req_s, px_s, py_s, hs_s, vs_s, de_s, rgbo_s), 64'd0);
    repeat (3) tick();
    chk("hold_rst_s", pack(fs_s, ls_s, req_s, px_s, py_s, hs_s, vs_s, de_s, rgbo_s), 64'd0);
    rst_s = 1'b0;
    run_table(1'b1, 1'b1, 12);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
